// File: rtl/sccb_pkg.sv
// Shared SCCB definitions: responder state encoding, OV7670 identity constants
// and the read-only sub-addresses. Also used by the camera driver.
package sccb_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ID,
        ST_ID_ACK,
        ST_SUB,
        ST_SUB_ACK,
        ST_DATA,
        ST_DATA_ACK,
        ST_RD,
        ST_RD_ACK,
        ST_IGNORE
    } sccb_state_e;

    localparam logic [7:0] OV7670_WR_ID = 8'h42;
    localparam logic [7:0] OV7670_RD_ID = 8'h43;
    localparam logic [7:0] OV7670_PID   = 8'h76;
    localparam logic [7:0] OV7670_VER   = 8'h73;
    localparam logic [7:0] PID_ADDR     = 8'h0A;
    localparam logic [7:0] VER_ADDR     = 8'h0B;

    // PID/VER are acknowledged on write but never overwritten.
    function automatic logic is_ro_addr(input logic [7:0] addr);
        return (addr == PID_ADDR) || (addr == VER_ADDR);
    endfunction

endpackage

// File: rtl/sccb_line_sync.sv
// Two-flop synchronizer for SIO_C/SIO_D plus edge and START/STOP detection.
// All outputs are single-cycle pulses except sda_lvl.
module sccb_line_sync (
    input  logic clk,
    input  logic reset_,
    input  logic scl_in,
    input  logic sda_in,
    output logic scl_rise,
    output logic scl_fall,
    output logic sda_lvl,
    output logic start_det,
    output logic stop_det
);
    logic [1:0] scl_sync_q, scl_sync_d;
    logic [1:0] sda_sync_q, sda_sync_d;
    logic       scl_prev_q, scl_prev_d;
    logic       sda_prev_q, sda_prev_d;
    logic       scl_lvl;

    always_comb begin
        scl_sync_d = {scl_sync_q[0], scl_in};
        sda_sync_d = {sda_sync_q[0], sda_in};
        scl_prev_d = scl_sync_q[1];
        sda_prev_d = sda_sync_q[1];
    end

    // Idle bus is high on both lines, so reset there to avoid phantom edges.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            scl_sync_q <= 2'b11;
            sda_sync_q <= 2'b11;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_sync_q <= scl_sync_d;
            sda_sync_q <= sda_sync_d;
            scl_prev_q <= scl_prev_d;
            sda_prev_q <= sda_prev_d;
        end
    end

    assign scl_lvl   = scl_sync_q[1];
    assign sda_lvl   = sda_sync_q[1];
    assign scl_rise  = scl_lvl & ~scl_prev_q;
    assign scl_fall  = ~scl_lvl & scl_prev_q;
    assign start_det = scl_lvl & scl_prev_q & sda_prev_q & ~sda_lvl;
    assign stop_det  = scl_lvl & scl_prev_q & ~sda_prev_q & sda_lvl;

endmodule

// File: rtl/sccb_responder.sv
// SCCB responder emulating the OV7670 control port: decodes ID, sub-address and
// data phases, acknowledges its own ID and serves reads from a 256x8 register file.
module sccb_responder
    import sccb_pkg::*;
#(
    parameter logic [7:0] DEV_ID   = OV7670_WR_ID,
    parameter logic [7:0] PID_VAL  = OV7670_PID,
    parameter logic [7:0] VER_VAL  = OV7670_VER,
    parameter int         HOLD_CYC = 4
) (
    input  logic       clk,
    input  logic       reset_,
    input  logic       SIO_C,
    input  logic       SIO_D_I,
    output logic       SIO_D_OE,
    output logic       reg_wr,
    output logic [7:0] reg_waddr,
    output logic [7:0] reg_wdata,
    input  logic [7:0] host_raddr,
    output logic [7:0] host_rdata,
    output logic       busy
);
    localparam int HW = $clog2(HOLD_CYC + 1);

    logic scl_rise, scl_fall, sda_lvl, start_det, stop_det;

    sccb_state_e   state_q, state_d;
    logic [3:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    ptr_q, ptr_d;
    logic          is_read_q, is_read_d;
    logic          busy_q, busy_d;
    logic          reg_wr_q, reg_wr_d;
    logic [7:0]    reg_waddr_q, reg_waddr_d;
    logic [7:0]    reg_wdata_q, reg_wdata_d;
    logic          oe_q, oe_d;
    logic          oe_tgt_q, oe_tgt_d;
    logic          oe_pend_q, oe_pend_d;
    logic [HW-1:0] hold_cnt_q, hold_cnt_d;
    logic [7:0]    rd_byte_q, host_rdata_q;
    logic [7:0]    mem_q [256];
    logic [7:0]    shift_in;
    logic          id_wr, id_rd, mem_we;

    sccb_line_sync u_sync (
        .clk       (clk),
        .reset_    (reset_),
        .scl_in    (SIO_C),
        .sda_in    (SIO_D_I),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .sda_lvl   (sda_lvl),
        .start_det (start_det),
        .stop_det  (stop_det)
    );

    assign shift_in = {shift_q[6:0], sda_lvl};
    assign id_wr    = (shift_q == DEV_ID);
    assign id_rd    = (shift_q == (DEV_ID | 8'h01));
    assign mem_we   = reg_wr_q && !is_ro_addr(reg_waddr_q);

    function automatic logic [7:0] rst_val(input logic [7:0] addr);
        if (addr == PID_ADDR) return PID_VAL;
        if (addr == VER_ADDR) return VER_VAL;
        return 8'h00;
    endfunction

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    // Phase changes happen on SIO_C falling edges, once the 8 data bits or the ACK bit are clocked.
    always_comb begin
        state_d = state_q;
        if (start_det) begin
            state_d = ST_ID;
        end else if (stop_det) begin
            state_d = ST_IDLE;
        end else if (scl_fall) begin
            case (state_q)
                ST_ID:       if (bit_cnt_q == 4'd8) state_d = (id_wr || id_rd) ? ST_ID_ACK : ST_IGNORE;
                ST_ID_ACK:   if (bit_cnt_q == 4'd1) state_d = is_read_q ? ST_RD : ST_SUB;
                ST_SUB:      if (bit_cnt_q == 4'd8) state_d = ST_SUB_ACK;
                ST_SUB_ACK:  if (bit_cnt_q == 4'd1) state_d = ST_DATA;
                ST_DATA:     if (bit_cnt_q == 4'd8) state_d = ST_DATA_ACK;
                ST_DATA_ACK: if (bit_cnt_q == 4'd1) state_d = ST_IGNORE;
                ST_RD:       if (bit_cnt_q == 4'd8) state_d = ST_RD_ACK;
                ST_RD_ACK:   if (bit_cnt_q == 4'd1) state_d = ST_IGNORE;
                default:     state_d = state_q;
            endcase
        end
    end

    always_comb begin
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        ptr_d       = ptr_q;
        is_read_d   = is_read_q;
        busy_d      = busy_q;
        reg_wr_d    = 1'b0;
        reg_waddr_d = reg_waddr_q;
        reg_wdata_d = reg_wdata_q;
        oe_d        = oe_q;
        oe_tgt_d    = oe_tgt_q;
        oe_pend_d   = oe_pend_q;
        hold_cnt_d  = hold_cnt_q;

        if (oe_pend_q) begin
            if (hold_cnt_q == '0) begin
                oe_d      = oe_tgt_q;
                oe_pend_d = 1'b0;
            end else begin
                hold_cnt_d = hold_cnt_q - 1'b1;
            end
        end

        // Every falling edge (and START/STOP) schedules a new OE level; release unless overridden.
        if (start_det || stop_det || scl_fall) begin
            oe_pend_d  = 1'b1;
            hold_cnt_d = HW'(HOLD_CYC - 1);
            oe_tgt_d   = 1'b0;
        end

        if (start_det || stop_det) begin
            bit_cnt_d = 4'd0;
            busy_d    = start_det;
        end else if (scl_rise) begin
            case (state_q)
                ST_ID, ST_SUB, ST_DATA: begin
                    if (bit_cnt_q != 4'd8) begin
                        shift_d   = shift_in;
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd7 && state_q == ST_SUB) ptr_d = shift_in;
                        if (bit_cnt_q == 4'd7 && state_q == ST_DATA) begin
                            reg_wr_d    = 1'b1;
                            reg_waddr_d = ptr_q;
                            reg_wdata_d = shift_in;
                        end
                    end
                end
                ST_RD:       if (bit_cnt_q != 4'd8) bit_cnt_d = bit_cnt_q + 4'd1;
                ST_ID_ACK, ST_SUB_ACK, ST_DATA_ACK, ST_RD_ACK: bit_cnt_d = 4'd1;
                default:     bit_cnt_d = bit_cnt_q;
            endcase
        end else if (scl_fall) begin
            case (state_q)
                ST_ID: begin
                    if (bit_cnt_q == 4'd8) begin
                        bit_cnt_d = 4'd0;
                        is_read_d = id_rd;
                        oe_tgt_d  = id_wr | id_rd;
                    end
                end
                ST_SUB, ST_DATA: begin
                    if (bit_cnt_q == 4'd8) begin
                        bit_cnt_d = 4'd0;
                        oe_tgt_d  = 1'b1;
                    end
                end
                ST_ID_ACK: begin
                    if (bit_cnt_q == 4'd1) begin
                        bit_cnt_d = 4'd0;
                        if (is_read_q) begin
                            shift_d  = rd_byte_q;
                            oe_tgt_d = ~rd_byte_q[7];
                        end
                    end
                end
                ST_SUB_ACK:  if (bit_cnt_q == 4'd1) bit_cnt_d = 4'd0;
                ST_RD: begin
                    if (bit_cnt_q == 4'd8) begin
                        bit_cnt_d = 4'd0;
                    end else begin
                        shift_d  = {shift_q[6:0], 1'b0};
                        oe_tgt_d = ~shift_q[6];
                    end
                end
                default:     bit_cnt_d = bit_cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            bit_cnt_q    <= 4'd0;
            shift_q      <= 8'h00;
            ptr_q        <= 8'h00;
            is_read_q    <= 1'b0;
            busy_q       <= 1'b0;
            reg_wr_q     <= 1'b0;
            reg_waddr_q  <= 8'h00;
            reg_wdata_q  <= 8'h00;
            oe_q         <= 1'b0;
            oe_tgt_q     <= 1'b0;
            oe_pend_q    <= 1'b0;
            hold_cnt_q   <= '0;
            rd_byte_q    <= 8'h00;
            host_rdata_q <= 8'h00;
        end else begin
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            ptr_q        <= ptr_d;
            is_read_q    <= is_read_d;
            busy_q       <= busy_d;
            reg_wr_q     <= reg_wr_d;
            reg_waddr_q  <= reg_waddr_d;
            reg_wdata_q  <= reg_wdata_d;
            oe_q         <= oe_d;
            oe_tgt_q     <= oe_tgt_d;
            oe_pend_q    <= oe_pend_d;
            hold_cnt_q   <= hold_cnt_d;
            rd_byte_q    <= mem_q[ptr_q];
            host_rdata_q <= mem_q[host_raddr];
        end
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            for (int i = 0; i < 256; i++) mem_q[i] <= rst_val(8'(i));
        end else if (mem_we) begin
            mem_q[reg_waddr_q] <= reg_wdata_q;
        end
    end

    assign SIO_D_OE   = oe_q;
    assign reg_wr     = reg_wr_q;
    assign reg_waddr  = reg_waddr_q;
    assign reg_wdata  = reg_wdata_q;
    assign host_rdata = host_rdata_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_sccb_responder.sv
// Bench for sccb_responder: an open-drain SCCB master model plus scoreboards of
// expected register writes and expected read bytes.
`timescale 1ns/1ps
module tb_sccb_responder;

    logic       clk = 1'b0;
    logic       reset_ = 1'b0;
    logic       SIO_C = 1'b1;
    logic       sda_m = 1'b1;
    logic       SIO_D_I;
    logic       SIO_D_OE;
    logic       reg_wr;
    logic [7:0] reg_waddr, reg_wdata;
    logic [7:0] host_raddr = 8'h00;
    logic [7:0] host_rdata;
    logic       busy;

    // Wired-AND bus: master drives sda_m, responder can only pull low.
    assign SIO_D_I = sda_m & ~SIO_D_OE;

    always #5 clk = ~clk;

    sccb_responder dut (
        .clk        (clk),
        .reset_     (reset_),
        .SIO_C      (SIO_C),
        .SIO_D_I    (SIO_D_I),
        .SIO_D_OE   (SIO_D_OE),
        .reg_wr     (reg_wr),
        .reg_waddr  (reg_waddr),
        .reg_wdata  (reg_wdata),
        .host_raddr (host_raddr),
        .host_rdata (host_rdata),
        .busy       (busy)
    );

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
    } wr_t;

    wr_t        exp_wr_q[$];
    logic [7:0] exp_rd_q[$];
    int         checks = 0;
    int         failures = 0;
    int         wr_seen = 0;
    int         wr_expected = 0;
    logic       oe_seen = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (SIO_D_OE) oe_seen = 1'b1;
        if (reset_ && reg_wr) begin
            wr_t e;
            wr_seen++;
            if (exp_wr_q.size() > 0) begin
                e = exp_wr_q.pop_front();
                check_val("wr_addr", reg_waddr, e.addr);
                check_val("wr_data", reg_wdata, e.data);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_wr(input logic [7:0] a, input logic [7:0] d);
        exp_wr_q.push_back({a, d});
        wr_expected++;
    endtask

    task automatic bus_start();
        if (SIO_C == 1'b0) begin
            wait_clk(5); sda_m = 1'b1;
            wait_clk(5); SIO_C = 1'b1;
        end
        wait_clk(5); sda_m = 1'b0;
        wait_clk(5); SIO_C = 1'b0;
    endtask

    task automatic bus_stop();
        wait_clk(5); sda_m = 1'b0;
        wait_clk(5); SIO_C = 1'b1;
        wait_clk(5); sda_m = 1'b1;
        wait_clk(10);
    endtask

    // One bit: 10 clk low (data changes mid-low), 10 clk high (sampled mid-high).
    task automatic clock_bit(input logic b, output logic line);
        wait_clk(5); sda_m = b;
        wait_clk(5); SIO_C = 1'b1;
        wait_clk(5); line = SIO_D_I;
        wait_clk(5); SIO_C = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input string tag, input logic exp_ack);
        logic line;
        for (int i = 7; i >= 0; i--) clock_bit(b[i], line);
        clock_bit(1'b1, line);
        check_val(tag, line, exp_ack ? 32'd0 : 32'd1);
    endtask

    task automatic read_byte(input logic nak, input string tag);
        logic [7:0] got;
        logic       line;
        logic [7:0] e;
        for (int i = 7; i >= 0; i--) begin
            clock_bit(1'b1, line);
            got[i] = line;
        end
        clock_bit(nak, line);
        if (exp_rd_q.size() > 0) begin
            e = exp_rd_q.pop_front();
            check_val(tag, got, e);
        end else begin
            check_val({tag, "_sb_empty"}, exp_rd_q.size(), 1);
        end
    endtask

    task automatic host_read(input logic [7:0] a, input logic [7:0] e, input string tag);
        host_raddr = a;
        wait_clk(1);
        check_val(tag, host_rdata, e);
    endtask

    task automatic read_txn(input logic [7:0] sub, input logic [7:0] e, input string tag);
        bus_start();
        send_byte(8'h42, {tag, "_id_ack"}, 1'b1);
        send_byte(sub, {tag, "_sub_ack"}, 1'b1);
        bus_stop();
        bus_start();
        send_byte(8'h43, {tag, "_rid_ack"}, 1'b1);
        exp_rd_q.push_back(e);
        read_byte(1'b1, {tag, "_rdata"});
        bus_stop();
        check_val({tag, "_oe_after_stop"}, SIO_D_OE, 0);
        $display("txn read sub=%02h exp=%02h", sub, e);
    endtask

    initial begin
        // Reset state
        wait_clk(3);
        check_val("rst_oe", SIO_D_OE, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_wr", reg_wr, 0);
        check_val("rst_waddr", reg_waddr, 0);
        check_val("rst_wdata", reg_wdata, 0);
        check_val("rst_hrdata", host_rdata, 0);
        reset_ = 1'b1;
        wait_clk(3);
        host_read(8'h0A, 8'h76, "rst_pid");
        host_read(8'h0B, 8'h73, "rst_ver");

        // 1: 3-phase write 42/12/80
        push_wr(8'h12, 8'h80);
        bus_start();
        check_val("t1_busy", busy, 1);
        send_byte(8'h42, "t1_id_ack", 1'b1);
        send_byte(8'h12, "t1_sub_ack", 1'b1);
        send_byte(8'h80, "t1_data_ack", 1'b1);
        bus_stop();
        check_val("t1_busy_end", busy, 0);
        check_val("t1_wr_count", wr_seen, wr_expected);
        host_read(8'h12, 8'h80, "t1_host_rd");
        $display("txn write 42/12/80");

        // 2: PID and VER reads
        read_txn(8'h0A, 8'h76, "t2_pid");
        read_txn(8'h0B, 8'h73, "t2_ver");

        // 3: write to read-only PID address
        push_wr(8'h0A, 8'hFF);
        bus_start();
        send_byte(8'h42, "t3_id_ack", 1'b1);
        send_byte(8'h0A, "t3_sub_ack", 1'b1);
        send_byte(8'hFF, "t3_data_ack", 1'b1);
        bus_stop();
        check_val("t3_wr_count", wr_seen, wr_expected);
        $display("txn write 42/0A/FF");
        read_txn(8'h0A, 8'h76, "t3_pid");
        host_read(8'h0A, 8'h76, "t3_host_pid");

        // 4: foreign ID
        oe_seen = 1'b0;
        bus_start();
        send_byte(8'h60, "t4_id_nak", 1'b0);
        send_byte(8'h55, "t4_data_nak", 1'b0);
        check_val("t4_busy", busy, 1);
        bus_stop();
        check_val("t4_busy_end", busy, 0);
        check_val("t4_oe_seen", oe_seen, 0);
        check_val("t4_wr_count", wr_seen, wr_expected);
        $display("txn write 60/55 (foreign id)");

        // 5: repeated START after 4 data bits keeps pointer, no write
        bus_start();
        send_byte(8'h42, "t5_id_ack", 1'b1);
        send_byte(8'h12, "t5_sub_ack", 1'b1);
        begin
            logic line;
            clock_bit(1'b1, line);
            clock_bit(1'b0, line);
            clock_bit(1'b1, line);
            clock_bit(1'b0, line);
        end
        bus_start();
        send_byte(8'h43, "t5_rid_ack", 1'b1);
        exp_rd_q.push_back(8'h80);
        read_byte(1'b1, "t5_rdata");
        bus_stop();
        check_val("t5_wr_count", wr_seen, wr_expected);
        $display("txn repeated-start read sub=12");

        // 6: async reset while ACK is driven
        bus_start();
        begin
            logic line;
            for (int i = 7; i >= 0; i--) clock_bit(1'b0 ^ (8'h42 >> i) & 1'b1, line);
        end
        wait_clk(5); sda_m = 1'b1;
        wait_clk(5); SIO_C = 1'b1;
        wait_clk(5);
        check_val("t6_ack_driven", SIO_D_OE, 1);
        #2 reset_ = 1'b0;
        #1;
        check_val("t6_oe_async", SIO_D_OE, 0);
        check_val("t6_busy_async", busy, 0);
        wait_clk(3);
        reset_ = 1'b1;
        wait_clk(3);
        host_read(8'h12, 8'h00, "t6_host_cleared");
        host_read(8'h0A, 8'h76, "t6_host_pid");
        oe_seen = 1'b0;
        wait_clk(5); SIO_C = 1'b0;
        send_byte(8'h42, "t6_nostart_id", 1'b0);
        send_byte(8'h12, "t6_nostart_sub", 1'b0);
        send_byte(8'h55, "t6_nostart_data", 1'b0);
        check_val("t6_busy_nostart", busy, 0);
        bus_stop();
        check_val("t6_oe_seen", oe_seen, 0);
        check_val("t6_wr_count", wr_seen, wr_expected);
        $display("txn reset mid-ack, then 42/12/55 without start");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
